// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdm_pkg
// Purpose  : Shared constants and helpers for the 1-bit PDM audio path
//            (modulator and CIC decimating decoder).
// Contents : CIC_ORDER, PCM_W, cic_width(), out_shift(), sat_unsigned()
// Revision : 1.0 - initial release
// ============================================================================
package pdm_pkg;

  // Number of integrator/comb sections in the decimator.
  localparam int CIC_ORDER = 3;

  // PCM sample width used by both the modulator input and decoder output.
  localparam int PCM_W = 16;

  // Register growth of an order-N CIC with unity differential delay is
  // N*log2(decim) bits on top of the 1-bit input.
  function automatic int cic_width(input int decim);
    return CIC_ORDER * $clog2(decim) + 1;
  endfunction

  // Right shift that maps the CIC full-scale (2^(W-1)) onto 2^out_w.
  // Clamped at zero so an OUT_W equal to the full CIC width still builds.
  function automatic int out_shift(input int decim, input int out_w);
    int s;
    s = cic_width(decim) - 1 - out_w;
    return (s < 0) ? 0 : s;
  endfunction

  // Unsigned saturation of val to out_w bits (all-ones on overflow).
  function automatic logic [31:0] sat_unsigned(input logic [31:0] val,
                                               input int          out_w);
    logic [31:0] max_val;
    max_val = (32'd1 << out_w) - 32'd1;
    return (val > max_val) ? max_val : val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_decoder_comb.sv
`default_nettype none
// ============================================================================
// Module   : cic_comb_chain
// Purpose  : Decimated comb section of the CIC: three delay registers,
//            subtract cascade, output scaling/saturation and warm-up gating.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            strobe            - one cycle per decimated sample
//            integ [W-1:0]     - last integrator output (registered)
//            sample [OUT_W-1:0]- scaled, saturated PCM sample
//            sample_strobe     - single-cycle pulse, sample is new
// Revision : 1.0 - initial release
// ============================================================================
module cic_comb_chain
  import pdm_pkg::*;
#(
  parameter int W     = 19,
  parameter int OUT_W = 16,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic [W-1:0]     integ,
  output logic [OUT_W-1:0] sample,
  output logic             sample_strobe
);

  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic [W-1:0] c1;
  logic [W-1:0] c2;
  logic [W-1:0] c3;
  logic [31:0]  c3_wide;
  logic [1:0]   warm;

  // Modulo-2^W differences; wrap in the integrators cancels here.
  always_comb begin
    c1      = integ - d1;
    c2      = c1 - d2;
    c3      = c2 - d3;
    c3_wide = {{(32 - W){1'b0}}, c3};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d1            <= '0;
      d2            <= '0;
      d3            <= '0;
      warm          <= 2'd0;
      sample        <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      if (strobe) begin
        d1 <= integ;
        d2 <= c1;
        d3 <= c2;
        // The first three evaluations only fill the delay line; their
        // outputs still contain the start-up transient.
        if (warm == 2'd3) begin
          sample        <= OUT_W'(sat_unsigned(c3_wide >> SHIFT, OUT_W));
          sample_strobe <= 1'b1;
        end else begin
          warm <= warm + 2'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pdm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pdm_decoder
// Purpose  : 3rd-order CIC decimating decoder turning a 1-bit unsigned PDM
//            stream into unsigned PCM samples.
// Ports    : clk          - system clock
//            reset        - synchronous active-high reset
//            pdm_in       - PDM bit (1 = full scale, 0 = zero)
//            pdm_en       - bit-accept strobe
//            sample_out   - decoded PCM sample [OUT_W-1:0]
//            sample_valid - single-cycle pulse with each new sample
// Revision : 1.0 - initial release
// ============================================================================
module pdm_decoder
  import pdm_pkg::*;
#(
  parameter int DECIM = 64,
  parameter int OUT_W = PCM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pdm_in,
  input  logic             pdm_en,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid
);

  localparam int W     = cic_width(DECIM);
  localparam int SHIFT = out_shift(DECIM, OUT_W);
  localparam int CNT_W = $clog2(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [W-1:0]     i1;
  logic [W-1:0]     i2;
  logic [W-1:0]     i3;
  logic [W-1:0]     i1_nxt;
  logic [W-1:0]     i2_nxt;
  logic [W-1:0]     i3_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             tick_d;

  // Integrator cascade: each stage adds the value the previous stage is
  // writing in this same cycle.
  always_comb begin
    i1_nxt = i1 + {{(W - 1){1'b0}}, pdm_in};
    i2_nxt = i2 + i1_nxt;
    i3_nxt = i3 + i2_nxt;
    tick   = pdm_en && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i1     <= '0;
      i2     <= '0;
      i3     <= '0;
      cnt    <= '0;
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick;
      if (pdm_en) begin
        i1  <= i1_nxt;
        i2  <= i2_nxt;
        i3  <= i3_nxt;
        cnt <= tick ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // tick_d is aligned with i3 already holding the tick bit's contribution.
  cic_comb_chain #(
    .W     (W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_comb (
    .clk           (clk),
    .reset         (reset),
    .strobe        (tick_d),
    .integ         (i3),
    .sample        (sample_out),
    .sample_strobe (sample_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_pdm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdm_decoder
// Purpose  : Directed self-checking bench for pdm_decoder (DECIM=64, 16 bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_decoder;

  logic        clk;
  logic        reset;
  logic        pdm_in;
  logic        pdm_en;
  logic [15:0] sample_out;
  logic        sample_valid;

  int checks;
  int errors;

  // Statistics gathered by run_stream
  int n_valid;
  int first_valid;
  int prev_valid;
  int bad_val;
  int bad_int;

  pdm_decoder #(
    .DECIM (64),
    .OUT_W (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pdm_in       (pdm_in),
    .pdm_en       (pdm_en),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Two reset cycles, then confirm the reset state of the outputs.
  task automatic do_reset();
    reset  = 1'b1;
    pdm_en = 1'b0;
    pdm_in = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_sample_out", {16'd0, sample_out}, 32'h0);
    check("rst_valid", {31'd0, sample_valid}, 32'h0);
    reset = 1'b0;
  endtask

  // mode 0: zeros, 1: ones, 2: alternating 1,0,
  //      3: en every 3rd cycle with in=1,
  //      4: en every 3rd cycle, accepted bits alternate, idle cycles in=1,
  //      5: first-order modulator model fed with sample 0x4000.
  // Outputs sampled after call k belong to cycle k+1.
  task automatic run_stream(input int n, input int mode, input int exp_val,
                            input int tol, input int period);
    int          acc_idx;
    logic [16:0] mod_acc;
    int          v;
    n_valid     = 0;
    first_valid = -1;
    prev_valid  = -1;
    bad_val     = 0;
    bad_int     = 0;
    acc_idx     = 0;
    mod_acc     = 17'd0;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0: begin pdm_en = 1'b1; pdm_in = 1'b0; end
        1: begin pdm_en = 1'b1; pdm_in = 1'b1; end
        2: begin pdm_en = 1'b1; pdm_in = ((k % 2) == 0); end
        3: begin pdm_en = ((k % 3) == 0); pdm_in = 1'b1; end
        4: begin
          pdm_en = ((k % 3) == 0);
          pdm_in = pdm_en ? ((acc_idx % 2) == 0) : 1'b1;
          if (pdm_en) acc_idx++;
        end
        default: begin
          mod_acc = {1'b0, mod_acc[15:0]} + 17'h04000;
          pdm_en  = 1'b1;
          pdm_in  = mod_acc[16];
        end
      endcase
      @(posedge clk);
      #1;
      if (sample_valid) begin
        n_valid++;
        if (first_valid < 0) first_valid = k + 1;
        if (prev_valid >= 0 && (k + 1 - prev_valid) != period) bad_int++;
        prev_valid = k + 1;
        v = int'(sample_out);
        if (v > exp_val + tol || v + tol < exp_val) bad_val++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    pdm_en = 1'b0;
    pdm_in = 1'b0;

    // Zero input: first valid in cycle 4*64+1, ticks 4..9 seen in 640 cycles.
    do_reset();
    run_stream(640, 0, 0, 0, 64);
    check("zero_first", first_valid, 257);
    check("zero_count", n_valid, 6);
    check("zero_values", bad_val, 0);
    check("zero_period", bad_int, 0);

    // Constant one: S = 2^16 saturates to 0xFFFF.
    do_reset();
    run_stream(640, 1, 16'hFFFF, 0, 64);
    check("ones_first", first_valid, 257);
    check("ones_count", n_valid, 6);
    check("ones_values", bad_val, 0);
    check("ones_period", bad_int, 0);

    // Alternating 1,0: exactly half scale.
    do_reset();
    run_stream(640, 2, 16'h8000, 0, 64);
    check("alt_count", n_valid, 6);
    check("alt_values", bad_val, 0);
    check("alt_period", bad_int, 0);

    // Enable every 3rd cycle: 4th tick bit accepted in cycle 765 -> valid 767.
    do_reset();
    run_stream(1152, 3, 16'hFFFF, 0, 192);
    check("en3_first", first_valid, 767);
    check("en3_count", n_valid, 3);
    check("en3_values", bad_val, 0);
    check("en3_period", bad_int, 0);

    // Bits presented while pdm_en=0 must be ignored.
    do_reset();
    run_stream(1152, 4, 16'h8000, 0, 192);
    check("en3alt_count", n_valid, 3);
    check("en3alt_values", bad_val, 0);
    check("en3alt_period", bad_int, 0);

    // Modulator loopback, long enough to wrap the integrators.
    do_reset();
    run_stream(64 * 64, 5, 16'h4000, 16'h0200, 64);
    check("loop_count", n_valid, 60);
    check("loop_values", bad_val, 0);
    check("loop_period", bad_int, 0);

    // Reset one clk after the 5th tick (tick bit in cycle 319).
    do_reset();
    run_stream(320, 1, 16'hFFFF, 0, 64);
    check("mid_pre_count", n_valid, 1);
    check("mid_pre_value", {16'd0, sample_out}, 32'hFFFF);
    reset  = 1'b1;
    pdm_en = 1'b1;
    pdm_in = 1'b1;
    @(posedge clk);
    #1;
    check("mid_valid", {31'd0, sample_valid}, 32'h0);
    check("mid_sample_out", {16'd0, sample_out}, 32'h0);
    reset = 1'b0;
    run_stream(320, 1, 16'hFFFF, 0, 64);
    check("mid_restart_first", first_valid, 257);
    check("mid_restart_count", n_valid, 1);
    check("mid_restart_value", bad_val, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
